// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives a variable-latency req/ack
// instruction-memory port and buffers fetched words in a 2-entry FIFO that
// feeds the Decode pipeline register. Redirects from Decode flush the FIFO
// and discard any wrong-path fetch still in flight.
// Optional build macro: FETCH_PERF_CNT_EN adds the o_perf_bubbles counter.
module fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_stall_F,
   input  logic        i_redirect,
   input  logic [31:0] i_pc_target,
   output logic        o_imem_req,
   output logic [31:0] o_imem_addr,
   input  logic        i_imem_ack,
   input  logic [31:0] i_imem_rdata,
   output logic        o_valid_F,
   output logic [31:0] o_instr_F,
   output logic [31:0] o_pc_F,
   output logic [31:0] o_pc_plus4_F
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0] o_perf_bubbles
`endif
);

   typedef enum logic [1:0] {FETCH, IDLE_FULL, DISCARD} state_t;

   state_t      state, state_nxt;
   logic [31:0] fetch_pc, fetch_pc_nxt;
   logic [31:0] target, target_nxt;
   logic        pending, pending_nxt;

   // queue slot 0 is the head and drives the F-stage outputs directly
   logic        v0, v1, v0_nxt, v1_nxt;
   logic [31:0] pc0, pc1, pc0_nxt, pc1_nxt;
   logic [31:0] instr0, instr1, instr0_nxt, instr1_nxt;

   logic [1:0]  count, count_after_deq;
   logic        deq, ack_ok, enq;
   logic [31:0] redirect_pc;

   assign redirect_pc     = {i_pc_target[31:2], 2'b00};
   assign count           = {1'b0, v0} + {1'b0, v1};
   assign deq             = v0 && !i_stall_F;
   assign count_after_deq = count - {1'b0, deq};

   // a raised request is held until ack; a new one issues only when a slot will be free
   assign o_imem_req = !i_rst && (pending || (state != IDLE_FULL && count_after_deq < 2'd2));
   assign ack_ok     = o_imem_req && i_imem_ack;
   assign enq        = ack_ok && (state == FETCH) && !i_redirect;

   assign o_imem_addr  = fetch_pc;
   assign o_valid_F    = v0;
   assign o_pc_F       = pc0;
   assign o_instr_F    = instr0;
   assign o_pc_plus4_F = pc0 + 32'd4;

   // next state, fetch PC and discard target; redirect outranks everything
   always_comb begin
      state_nxt    = state;
      fetch_pc_nxt = fetch_pc;
      target_nxt   = target;
      pending_nxt  = o_imem_req && !i_imem_ack;
      if (i_redirect) begin
         if (o_imem_req && !i_imem_ack) begin
            // old-path request must still complete; remember where to go afterwards
            state_nxt  = DISCARD;
            target_nxt = redirect_pc;
         end else begin
            state_nxt    = FETCH;
            fetch_pc_nxt = redirect_pc;
         end
      end else begin
         case (state)
            FETCH: begin
               if (ack_ok) begin
                  fetch_pc_nxt = fetch_pc + 32'd4;
                  if (count_after_deq == 2'd1) state_nxt = IDLE_FULL;
               end
            end
            IDLE_FULL: begin
               if (deq) state_nxt = FETCH;
            end
            DISCARD: begin
               if (ack_ok) begin
                  state_nxt    = FETCH;
                  fetch_pc_nxt = target;
               end
            end
            default: state_nxt = FETCH;
         endcase
      end
   end

   // FSM, PC and outstanding-request register
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state    <= FETCH;
         fetch_pc <= RESET_PC;
         target   <= RESET_PC;
         pending  <= 1'b0;
      end else begin
         state    <= state_nxt;
         fetch_pc <= fetch_pc_nxt;
         target   <= target_nxt;
         pending  <= pending_nxt;
      end
   end

   // queue update: flush on redirect, else shift on dequeue then fill first free slot
   always_comb begin
      v0_nxt     = v0;
      v1_nxt     = v1;
      pc0_nxt    = pc0;
      pc1_nxt    = pc1;
      instr0_nxt = instr0;
      instr1_nxt = instr1;
      if (i_redirect) begin
         v0_nxt = 1'b0;
         v1_nxt = 1'b0;
      end else begin
         if (deq) begin
            v0_nxt     = v1;
            pc0_nxt    = pc1;
            instr0_nxt = instr1;
            v1_nxt     = 1'b0;
         end
         if (enq) begin
            if (!v0_nxt) begin
               v0_nxt     = 1'b1;
               pc0_nxt    = fetch_pc;
               instr0_nxt = i_imem_rdata;
            end else begin
               v1_nxt     = 1'b1;
               pc1_nxt    = fetch_pc;
               instr1_nxt = i_imem_rdata;
            end
         end
      end
      // an empty head presents a NOP at PC 0 to Decode
      if (!v0_nxt) begin
         pc0_nxt    = 32'd0;
         instr0_nxt = NOP_INSTR;
      end
   end

   // queue storage; only the head (visible outputs) and valid bits need reset values
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         v0     <= 1'b0;
         v1     <= 1'b0;
         pc0    <= 32'd0;
         instr0 <= NOP_INSTR;
      end else begin
         v0     <= v0_nxt;
         v1     <= v1_nxt;
         pc0    <= pc0_nxt;
         instr0 <= instr0_nxt;
      end
      pc1    <= pc1_nxt;
      instr1 <= instr1_nxt;
   end

`ifdef FETCH_PERF_CNT_EN
   // bubble counter: empty head with no redirect this cycle, saturating
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_perf_bubbles <= 32'd0;
      end else if (!v0 && !i_redirect && (o_perf_bubbles != 32'hFFFF_FFFF)) begin
         o_perf_bubbles <= o_perf_bubbles + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed-vector bench for fetch_unit: a table of per-cycle inputs with
// hand-computed outputs, plus a hand-built 4-wait-state memory sequence.
module tb_fetch_unit;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk;
   logic        rst;
   logic        stall;
   logic        redirect;
   logic [31:0] pc_target;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        valid;
   logic [31:0] instr;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_bubbles;
`endif

   int vectors = 0;
   int miscompares = 0;

   fetch_unit dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_stall_F    (stall),
      .i_redirect   (redirect),
      .i_pc_target  (pc_target),
      .o_imem_req   (imem_req),
      .o_imem_addr  (imem_addr),
      .i_imem_ack   (imem_ack),
      .i_imem_rdata (imem_rdata),
      .o_valid_F    (valid),
      .o_instr_F    (instr),
      .o_pc_F       (pc),
      .o_pc_plus4_F (pc_plus4)
`ifdef FETCH_PERF_CNT_EN
      ,
      .o_perf_bubbles (perf_bubbles)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        stall;
      logic        redir;
      logic [31:0] tgt;
      logic        ack;
      logic [31:0] rdata;
      logic        req;
      logic [31:0] addr;
      logic        valid;
      logic [31:0] pc;
      logic [31:0] instr;
   } vec_t;

   vec_t tv[$];

   function automatic vec_t mk(input logic r, input logic s, input logic rd, input logic [31:0] t,
                               input logic a, input logic [31:0] d, input logic q,
                               input logic [31:0] ad, input logic v, input logic [31:0] p,
                               input logic [31:0] i);
      vec_t x;
      x.rst = r; x.stall = s; x.redir = rd; x.tgt = t; x.ack = a; x.rdata = d;
      x.req = q; x.addr = ad; x.valid = v; x.pc = p; x.instr = i;
      return x;
   endfunction

   task automatic chk(input string tag, input string field, input logic [31:0] act,
                      input logic [31:0] exp);
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s %s: got %h expected %h", tag, field, act, exp);
      end
   endtask

   // drive one cycle of inputs, compare at the falling edge, advance past the rising edge
   task automatic apply(input vec_t v, input string tag);
      rst        = v.rst;
      stall      = v.stall;
      redirect   = v.redir;
      pc_target  = v.tgt;
      imem_ack   = v.ack;
      imem_rdata = v.rdata;
      @(negedge clk);
      vectors++;
      chk(tag, "req",    {31'd0, imem_req}, {31'd0, v.req});
      chk(tag, "addr",   imem_addr, v.addr);
      chk(tag, "valid",  {31'd0, valid}, {31'd0, v.valid});
      chk(tag, "pc",     pc, v.pc);
      chk(tag, "instr",  instr, v.instr);
      chk(tag, "plus4",  pc_plus4, v.pc + 32'd4);
      @(posedge clk);
      #1;
   endtask

   task automatic reset_edge();
      rst = 1'b1; stall = 1'b0; redirect = 1'b0; pc_target = 32'd0;
      imem_ack = 1'b0; imem_rdata = 32'd0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      // zero-wait fetch from reset
      tv.push_back(mk(1,0,0,32'h0,0,32'h0,        0,32'h0,0,32'h0,NOP));
      tv.push_back(mk(0,0,0,32'h0,1,32'hA000_0000, 1,32'h0,0,32'h0,NOP));
      tv.push_back(mk(0,0,0,32'h0,1,32'hA000_0004, 1,32'h4,1,32'h0,32'hA000_0000));
      tv.push_back(mk(0,0,0,32'h0,1,32'hA000_0008, 1,32'h8,1,32'h4,32'hA000_0004));
      tv.push_back(mk(0,0,0,32'h0,0,32'h0,         1,32'hC,1,32'h8,32'hA000_0008));
      // reset mid-request, then five stall cycles filling the queue
      tv.push_back(mk(1,0,0,32'h0,0,32'h0,         0,32'hC,0,32'h0,NOP));
      tv.push_back(mk(1,0,0,32'h0,0,32'h0,         0,32'h0,0,32'h0,NOP));
      tv.push_back(mk(0,1,0,32'h0,1,32'hA000_0000, 1,32'h0,0,32'h0,NOP));
      tv.push_back(mk(0,1,0,32'h0,1,32'hA000_0004, 1,32'h4,1,32'h0,32'hA000_0000));
      tv.push_back(mk(0,1,0,32'h0,0,32'h0,         0,32'h8,1,32'h0,32'hA000_0000));
      tv.push_back(mk(0,1,0,32'h0,1,32'hDEAD_BEEF, 0,32'h8,1,32'h0,32'hA000_0000));
      tv.push_back(mk(0,1,0,32'h0,0,32'h0,         0,32'h8,1,32'h0,32'hA000_0000));
      tv.push_back(mk(0,0,0,32'h0,0,32'h0,         0,32'h8,1,32'h0,32'hA000_0000));
      tv.push_back(mk(0,0,0,32'h0,1,32'hA000_0008, 1,32'h8,1,32'h4,32'hA000_0004));
      tv.push_back(mk(0,0,0,32'h0,0,32'h0,         1,32'hC,1,32'h8,32'hA000_0008));
      // redirect to 0x100 while the 0x8 fetch waits three cycles
      tv.push_back(mk(1,0,0,32'h0,0,32'h0,         0,32'hC,0,32'h0,NOP));
      tv.push_back(mk(1,0,0,32'h0,0,32'h0,         0,32'h0,0,32'h0,NOP));
      tv.push_back(mk(0,0,0,32'h0,1,32'hA000_0000, 1,32'h0,0,32'h0,NOP));
      tv.push_back(mk(0,0,0,32'h0,1,32'hA000_0004, 1,32'h4,1,32'h0,32'hA000_0000));
      tv.push_back(mk(0,0,0,32'h0,0,32'h0,         1,32'h8,1,32'h4,32'hA000_0004));
      tv.push_back(mk(0,0,1,32'h100,0,32'h0,       1,32'h8,0,32'h0,NOP));
      tv.push_back(mk(0,0,0,32'h0,0,32'h0,         1,32'h8,0,32'h0,NOP));
      tv.push_back(mk(0,0,0,32'h0,1,32'hA000_0008, 1,32'h8,0,32'h0,NOP));
      tv.push_back(mk(0,0,0,32'h0,0,32'h0,         1,32'h100,0,32'h0,NOP));
      tv.push_back(mk(0,0,0,32'h0,1,32'hA000_0100, 1,32'h100,0,32'h0,NOP));
      tv.push_back(mk(0,0,0,32'h0,1,32'hA000_0104, 1,32'h104,1,32'h100,32'hA000_0100));
      // redirect (unaligned target) in the same cycle as an ack
      tv.push_back(mk(0,0,1,32'h203,1,32'hA000_0108, 1,32'h108,1,32'h104,32'hA000_0104));
      tv.push_back(mk(0,0,0,32'h0,0,32'h0,         1,32'h200,0,32'h0,NOP));
      tv.push_back(mk(0,0,0,32'h0,1,32'hA000_0200, 1,32'h200,0,32'h0,NOP));
      tv.push_back(mk(0,0,0,32'h0,0,32'h0,         1,32'h204,1,32'h200,32'hA000_0200));
      // reset during a pending request
      tv.push_back(mk(1,0,0,32'h0,0,32'h0,         0,32'h204,0,32'h0,NOP));
      tv.push_back(mk(1,0,0,32'h0,0,32'h0,         0,32'h0,0,32'h0,NOP));
      tv.push_back(mk(0,0,0,32'h0,0,32'h0,         1,32'h0,0,32'h0,NOP));
      tv.push_back(mk(0,0,0,32'h0,1,32'hA000_0000, 1,32'h0,0,32'h0,NOP));
      // redirect to the top word, PC wraps to 0
      tv.push_back(mk(0,0,1,32'hFFFF_FFFC,1,32'hA000_0004, 1,32'h4,1,32'h0,32'hA000_0000));
      tv.push_back(mk(0,0,0,32'h0,1,32'hB000_FFFC, 1,32'hFFFF_FFFC,0,32'h0,NOP));
      tv.push_back(mk(0,0,0,32'h0,0,32'h0,         1,32'h0,1,32'hFFFF_FFFC,32'hB000_FFFC));
      // two redirects while discarding; the second target wins
      tv.push_back(mk(0,0,1,32'h300,0,32'h0,       1,32'h0,0,32'h0,NOP));
      tv.push_back(mk(0,0,1,32'h400,0,32'h0,       1,32'h0,0,32'h0,NOP));
      tv.push_back(mk(0,0,0,32'h0,1,32'hDEAD_0000, 1,32'h0,0,32'h0,NOP));
      tv.push_back(mk(0,0,0,32'h0,1,32'hA000_0400, 1,32'h400,0,32'h0,NOP));
      tv.push_back(mk(0,0,0,32'h0,0,32'h0,         1,32'h404,1,32'h400,32'hA000_0400));

      @(posedge clk);
      #1;
      reset_edge();
      for (int i = 0; i < tv.size(); i++) apply(tv[i], $sformatf("v%0d", i));

      // 4-wait-state memory, no stalls, three instructions
      reset_edge();
      apply(mk(1,0,0,32'h0,0,32'h0, 0,32'h0,0,32'h0,NOP), "ws_reset");
`ifdef FETCH_PERF_CNT_EN
      vectors++;
      chk("perf_reset", "bubbles", perf_bubbles, 32'd0);
`endif
      for (int c = 0; c < 16; c++) begin
         vec_t v;
         logic        a;
         logic [31:0] ea;
         a  = (c == 4) || (c == 9) || (c == 14);
         ea = (c < 5) ? 32'h0 : (c < 10) ? 32'h4 : (c < 15) ? 32'h8 : 32'hC;
         v  = mk(0,0,0,32'h0, a, a ? (32'hC000_0000 + 32'((c / 5) * 4)) : 32'h0,
                 1, ea, 0, 32'h0, NOP);
         if (c == 5)  begin v.valid = 1; v.pc = 32'h0; v.instr = 32'hC000_0000; end
         if (c == 10) begin v.valid = 1; v.pc = 32'h4; v.instr = 32'hC000_0004; end
         if (c == 15) begin v.valid = 1; v.pc = 32'h8; v.instr = 32'hC000_0008; end
         apply(v, $sformatf("ws%0d", c));
      end
`ifdef FETCH_PERF_CNT_EN
      // bubbles: cycles 0-4, 6-9, 11-14 had an empty head
      @(negedge clk);
      vectors++;
      chk("perf_count", "bubbles", perf_bubbles, 32'd13);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
